// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing defaults, total helpers and shared coordinate type
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - DEPTH x WIDTH shift register with per-bit reset value
module vga_sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, syncs and blank qualifier
// Optional: VGA_TIMING_SYNC_DELAY_EN delays hs/vs/blank by SYNC_DELAY cycles.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int SYNC_DELAY = 2
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output logic   line_end,
  output logic   frame_end
);

  localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  if (H_TOTAL > COORD_MAX) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, COORD_MAX);
  end
  if (V_TOTAL > COORD_MAX) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, COORD_MAX);
  end
  if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_delay_check
    $error("vga_timing_gen: SYNC_DELAY %0d outside 1..4", SYNC_DELAY);
  end

  coord_t hc, vc, hc_nxt, vc_nxt;
  logic   h_wrap, v_last;
  logic   hs_r, vs_r, blank_r;

  always_comb begin
    h_wrap = (int'(hc) == H_TOTAL - 1);
    v_last = (int'(vc) == V_TOTAL - 1);
    hc_nxt = h_wrap ? '0 : hc + coord_t'(1);
    vc_nxt = vc;
    if (h_wrap) vc_nxt = v_last ? '0 : vc + coord_t'(1);
  end

  // Qualifiers decode the next counter values so they land in the same cycle as DrawX/DrawY.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc        <= '0;
      vc        <= '0;
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_r   <= 1'b1;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      hc        <= hc_nxt;
      vc        <= vc_nxt;
      hs_r      <= !(int'(hc_nxt) >= HS_START && int'(hc_nxt) < HS_END);
      vs_r      <= !(int'(vc_nxt) >= VS_START && int'(vc_nxt) < VS_END);
      blank_r   <= (int'(hc_nxt) < H_ACTIVE) && (int'(vc_nxt) < V_ACTIVE);
      line_end  <= (int'(hc_nxt) == H_TOTAL - 1);
      frame_end <= (int'(hc_nxt) == H_TOTAL - 1) && (int'(vc_nxt) == V_TOTAL - 1);
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  // Stages reset to the blanking values of the pixels just before (0,0): hs=1, vs=1, blank=0.
  vga_sync_delay #(
    .DEPTH   (SYNC_DELAY),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .din     ({hs_r, vs_r, blank_r}),
    .dout    ({hs, vs, blank})
  );
`else
  assign hs    = hs_r;
  assign vs    = vs_r;
  assign blank = blank_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - table-driven bench for vga_timing_gen (default and VGA_TIMING_SYNC_DELAY_EN builds)
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam logic RST_BLANK = (D > 0) ? 1'b0 : 1'b1;
  localparam int N = 1700;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_s_n = 1'b0;
  logic [9:0] dx, dy, sx, sy;
  logic       hs, vs, blank, le, fe;
  logic       shs, svs, sblank, sle, sfe;

  always #5 clk = ~clk;

  vga_timing_gen #(.SYNC_DELAY(2)) dut (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(dx), .DrawY(dy),
    .hs(hs), .vs(vs), .blank(blank), .line_end(le), .frame_end(fe)
  );

  // Small raster: 16 pixels x 8 lines, hs low at x 10..12, vs low on lines 5..6.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(2)
  ) dut_s (
    .vga_clk(clk), .reset_n(rst_s_n), .DrawX(sx), .DrawY(sy),
    .hs(shs), .vs(svs), .blank(sblank), .line_end(sle), .frame_end(sfe)
  );

  typedef struct {
    int         k;
    logic [9:0] x, y;
    logic       hs, vs, blank, le, fe;
  } vec_t;

  vec_t       vecs [13];
  int         tests = 0;
  int         fails = 0;
  logic [9:0] hx [N];
  logic [9:0] hy [N];
  logic [2:0] hsync [N];
  logic [1:0] hpulse [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int hs_low, first_hs, first_bl, le_cnt, y_chg, s_hs, s_vs, s_fe, ks, wait_cnt;
    logic [2:0] esync;
    logic [22:0] sexp;

    vecs[0]  = '{0,    0,   0, 1, 1, 1, 0, 0};
    vecs[1]  = '{1,    1,   0, 1, 1, 1, 0, 0};
    vecs[2]  = '{639,  639, 0, 1, 1, 1, 0, 0};
    vecs[3]  = '{640,  640, 0, 1, 1, 0, 0, 0};
    vecs[4]  = '{655,  655, 0, 1, 1, 0, 0, 0};
    vecs[5]  = '{656,  656, 0, 0, 1, 0, 0, 0};
    vecs[6]  = '{751,  751, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{752,  752, 0, 1, 1, 0, 0, 0};
    vecs[8]  = '{799,  799, 0, 1, 1, 0, 1, 0};
    vecs[9]  = '{800,  0,   1, 1, 1, 1, 0, 0};
    vecs[10] = '{1439, 639, 1, 1, 1, 1, 0, 0};
    vecs[11] = '{1599, 799, 1, 1, 1, 0, 1, 0};
    vecs[12] = '{1600, 0,   2, 1, 1, 1, 0, 0};

    repeat (5) @(posedge clk);
    #2;
    chk("reset_main", {dx, dy, hs, vs, blank, le, fe}, {10'd0, 10'd0, 1'b1, 1'b1, RST_BLANK, 1'b0, 1'b0});
    chk("reset_small", {sx, sy, shs, svs, sblank, sle, sfe}, {10'd0, 10'd0, 1'b1, 1'b1, RST_BLANK, 1'b0, 1'b0});

    @(negedge clk);
    #1;
    rst_n = 1'b1;
    rst_s_n = 1'b1;
    #1;

    s_hs = 0; s_vs = 0; s_fe = 0;
    for (int k = 0; k < N; k++) begin
      hx[k] = dx; hy[k] = dy;
      hsync[k] = {hs, vs, blank};
      hpulse[k] = {le, fe};
      if (k < 256) begin
        ks = k - D;
        if (ks < 0) esync = {1'b1, 1'b1, 1'b0};
        else esync = {!((ks % 16) >= 10 && (ks % 16) < 13),
                      !(((ks / 16) % 8) >= 5 && ((ks / 16) % 8) < 7),
                      ((ks % 16) < 8) && (((ks / 16) % 8) < 4)};
        sexp = {10'(k % 16), 10'((k / 16) % 8), (k % 16) == 15, (k % 128) == 127, esync};
        chk($sformatf("small_k%0d", k), {9'd0, sx, sy, sle, sfe, shs, svs, sblank}, {9'd0, sexp});
        s_hs += int'(!shs);
        s_vs += int'(!svs);
        s_fe += int'(sfe);
      end
      @(posedge clk);
      #2;
    end
    chk("small_hs_low_cycles", s_hs, 48);
    chk("small_vs_low_cycles", s_vs, 64);
    chk("small_frame_end_count", s_fe, 2);

    foreach (vecs[i]) begin
      chk($sformatf("vec%0d_coord", vecs[i].k), {hx[vecs[i].k], hy[vecs[i].k], hpulse[vecs[i].k]},
          {vecs[i].x, vecs[i].y, vecs[i].le, vecs[i].fe});
      chk($sformatf("vec%0d_sync", vecs[i].k), hsync[vecs[i].k + D], {vecs[i].hs, vecs[i].vs, vecs[i].blank});
    end
    chk("first_cycles_sync0", hsync[0], (D > 0) ? 3'b110 : 3'b111);
    chk("first_cycles_sync1", hsync[1], (D > 0) ? 3'b110 : 3'b111);

    hs_low = 0; first_hs = -1; first_bl = -1; le_cnt = 0; y_chg = -1;
    for (int k = 0; k < 800; k++) begin
      hs_low += int'(!hsync[k + D][2]);
      if (first_hs < 0 && !hsync[k + D][2]) first_hs = k + D;
      if (first_bl < 0 && !hsync[k + D][0]) first_bl = k + D;
      le_cnt += int'(hpulse[k][1]);
    end
    for (int k = 1; k < N; k++) if (y_chg < 0 && hy[k] != hy[k-1]) y_chg = k;
    chk("line_hs_low_cycles", hs_low, 96);
    chk("line_hs_fall_index", first_hs, 656 + D);
    chk("line_blank_fall_index", first_bl, 640 + D);
    chk("line_end_count", le_cnt, 1);
    chk("drawy_step_index", y_chg, 800);

    wait_cnt = 0;
    while (dx != 10'd300 && wait_cnt < 1000) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    chk("reach_300_2", {dx, dy}, {10'd300, 10'd2});
    #2;
    rst_n = 1'b0;
    #1;
    chk("midframe_async_reset", {dx, dy, hs, vs, blank, le, fe}, {10'd0, 10'd0, 1'b1, 1'b1, RST_BLANK, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("restart_coord0", {dx, dy}, {10'd0, 10'd0});
    @(posedge clk);
    #2;
    chk("restart_coord1", {dx, dy}, {10'd1, 10'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the VGA raster that all pixel renderers consume: DrawX/DrawY coordinates, the active-video `blank` qualifier, and active-low hs/vs syncs. Default timing is 640x480 @ 60 Hz on a 25 MHz vga_clk.
- It is the producing end of the DrawX/DrawY/blank interface. Renderers (ROM-indexed backgrounds, sprites) read coordinates from it and gate their colour outputs with `blank`.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_DELAY, 2, pipeline depth applied to hs/vs/blank when VGA_TIMING_SYNC_DELAY_EN is defined (range 1..4)

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = active video (draw), 0 = blanking
- line_end  out  1  one-cycle pulse on the last pixel of every line
- frame_end  out  1  one-cycle pulse on the last pixel of every frame

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both totals must be ≤ 1024; elaboration fails otherwise.
- Interface: one clock (vga_clk); reset is asynchronous and active-low (reset_n).
- Reset values: hc=0, vc=0, DrawX=0, DrawY=0, hs=1, vs=1, blank=1, line_end=0, frame_end=0.
- Counters:
  - hc increments every cycle and wraps from H_TOTAL-1 to 0.
  - vc increments only on the cycle hc wraps, and wraps from V_TOTAL-1 to 0 on the same cycle both counters wrap.
  - DrawX = hc and DrawY = vc, driven directly from the registers.
- All other outputs are registered. They are computed from the next-state counter values, so they are coherent with DrawX/DrawY in the same cycle and glitch-free:
  - hs = 0 iff H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs = 0 iff V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC (490..491)
  - blank = 1 iff hc < H_ACTIVE and vc < V_ACTIVE
  - line_end = 1 iff hc == H_TOTAL-1
  - frame_end = 1 iff hc == H_TOTAL-1 and vc == V_TOTAL-1
- Latency: zero cycles between a coordinate and its qualifiers. Renderers with N-cycle colour latency compensate themselves, or use the optional delay.
- Boundaries:
  - vs transitions occur on the same cycle hc wraps to 0; vsync is line-aligned.
  - Frame period is exactly H_TOTAL*V_TOTAL cycles (420000). There are no skipped or duplicated counts.
- Reset mid-frame: all state returns to reset values immediately (asynchronously). Counting resumes at (0,0) on the first vga_clk edge after reset_n deasserts.

Optional Feature:
- Macro: VGA_TIMING_SYNC_DELAY_EN.
- Defined:
  - hs, vs and blank pass through a SYNC_DELAY-stage shift register, so they align with a renderer whose colour output lags DrawX/DrawY by SYNC_DELAY cycles (ROM read plus output register = 2).
  - Delay stages reset to the blanking-region values of the pixels preceding (0,0): hs=1, vs=1, blank=0.
  - DrawX, DrawY, line_end and frame_end are not delayed.
- Undefined: no delay; behaviour exactly as above.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing localparams (640x480 set);
  - H_TOTAL/V_TOTAL helper functions;
  - typedef coord_t (logic [9:0]), shared with renderers.
- One sub-module, vga_sync_delay: a parameterised DEPTH x WIDTH shift register with per-bit reset value, used only under the macro.

Test Plan:
- Reset release: hold reset_n=0 for 5 cycles, then release. Required: DrawX=0, DrawY=0, blank=1, hs=1, vs=1 at the first edge; DrawX=1 at the second.
- Line timing: run one line. Required:
  - hs low for exactly 96 cycles, starting at DrawX=656;
  - blank=0 from DrawX=640 through 799;
  - line_end high only at DrawX=799;
  - DrawY increments when DrawX goes 799→0.
- Frame timing: run 2 frames. Required:
  - vs low for lines 490–491 only (1600 cycles);
  - frame_end pulses exactly once per 420000 cycles, at (799,524);
  - (799,524) is followed by (0,0).
- Mid-frame reset: assert reset_n=0 asynchronously at (300,200), between edges. Required: outputs reach reset values before the next edge; after release, the raster restarts at (0,0).
- Delay feature: with the macro defined and SYNC_DELAY=2, compare against an undelayed reference model. Required:
  - blank rises 2 cycles after DrawX=0/DrawY=0;
  - hs falls at DrawX=658;
  - first 2 cycles after reset show blank=0, hs=1, vs=1.
- Parameter sweep: instantiate with 800x600 timing (40/128/88 horizontal, 1/4/23 vertical). Required: H_TOTAL=1056 fails elaboration; a variant with H_TOTAL ≤ 1024 counts correctly.
